// File: rtl/input_debouncer_if.sv
// Debouncer signal bundle: raw level in, conditioned level and diagnostics out.
interface input_debouncer_if #(
   parameter int unsigned BOUNCE_W = 8
);
   logic                d_raw;
   logic                d_clean;
   logic                busy;
   logic [BOUNCE_W-1:0] bounce_cnt;

   // Stimulus side drives the raw level and observes the conditioned outputs.
   modport master (
      output d_raw,
      input  d_clean,
      input  busy,
      input  bounce_cnt
   );

   // Debouncer side.
   modport slave (
      input  d_raw,
      output d_clean,
      output busy,
      output bounce_cnt
   );
endinterface

// File: rtl/input_debouncer.sv
// Input debouncer: synchroniser chain followed by a four-state qualification FSM.
// A new level is committed to d_clean only after DEBOUNCE_CYCLES consecutive
// synchronised samples at that level; aborted candidates bump a saturating counter.
module input_debouncer #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8,
   parameter int unsigned BOUNCE_W        = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input_debouncer_if.slave    dbg_if
);

   typedef enum logic [1:0] {
      StStableLo = 2'd0,
      StCheckHi  = 2'd1,
      StStableHi = 2'd2,
      StCheckLo  = 2'd3
   } state_e;

   // Count value at which the next matching sample completes qualification.
   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   d_sync;
   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       stab_cnt_q, stab_cnt_d;
   logic                   d_clean_q, d_clean_d;
   logic [BOUNCE_W-1:0]    bounce_q, bounce_d;
   logic                   bounce_inc;

   assign d_sync = sync_q[SYNC_STAGES-1];

   // Synchroniser shift chain for the asynchronous raw input.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], dbg_if.d_raw};
      end
   end

   // Qualification FSM next-state logic.
   always_comb begin
      state_d    = state_q;
      stab_cnt_d = stab_cnt_q;
      d_clean_d  = d_clean_q;
      bounce_inc = 1'b0;
      unique case (state_q)
         StStableLo: begin
            if (d_sync) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d    = StStableHi;
                  d_clean_d  = 1'b1;
                  stab_cnt_d = '0;
               end else begin
                  state_d    = StCheckHi;
                  stab_cnt_d = CNT_W'(1);
               end
            end
         end
         StCheckHi: begin
            if (!d_sync) begin
               state_d    = StStableLo;
               stab_cnt_d = '0;
               bounce_inc = 1'b1;
            end else if (stab_cnt_q == LastCnt) begin
               state_d    = StStableHi;
               d_clean_d  = 1'b1;
               stab_cnt_d = '0;
            end else begin
               stab_cnt_d = stab_cnt_q + 1'b1;
            end
         end
         StStableHi: begin
            if (!d_sync) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d    = StStableLo;
                  d_clean_d  = 1'b0;
                  stab_cnt_d = '0;
               end else begin
                  state_d    = StCheckLo;
                  stab_cnt_d = CNT_W'(1);
               end
            end
         end
         StCheckLo: begin
            if (d_sync) begin
               state_d    = StStableHi;
               stab_cnt_d = '0;
               bounce_inc = 1'b1;
            end else if (stab_cnt_q == LastCnt) begin
               state_d    = StStableLo;
               d_clean_d  = 1'b0;
               stab_cnt_d = '0;
            end else begin
               stab_cnt_d = stab_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d    = StStableLo;
            stab_cnt_d = '0;
            d_clean_d  = 1'b0;
         end
      endcase
   end

   // Bounce counter saturates at all-ones instead of wrapping.
   always_comb begin
      bounce_d = bounce_q;
      if (bounce_inc && (bounce_q != '1)) begin
         bounce_d = bounce_q + 1'b1;
      end
   end

   // State, counters and registered output level.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StStableLo;
         stab_cnt_q <= '0;
         d_clean_q  <= 1'b0;
         bounce_q   <= '0;
      end else begin
         state_q    <= state_d;
         stab_cnt_q <= stab_cnt_d;
         d_clean_q  <= d_clean_d;
         bounce_q   <= bounce_d;
      end
   end

   assign dbg_if.d_clean    = d_clean_q;
   assign dbg_if.busy       = (state_q == StCheckHi) || (state_q == StCheckLo);
   assign dbg_if.bounce_cnt = bounce_q;

endmodule
